// File: rtl/zcash_fpga_pkg.sv
// Shared host-interface types: command codes, message header, engine destinations
// and the helpers that decode a header into a destination and a word count.
package zcash_fpga_pkg;

  typedef enum logic [31:0] {
    RESET_FPGA           = 32'h0000_0000,
    FPGA_STATUS          = 32'h0000_0001,
    VERIFY_EQUIHASH      = 32'h0000_0100,
    VERIFY_SECP256K1_SIG = 32'h0000_0101,
    FPGA_IGNORE_RPL      = 32'h8000_0000,
    FPGA_STATUS_RPL      = 32'h8000_0001,
    VERIFY_EQUIHASH_RPL  = 32'h8000_0100,
    VERIFY_SECP256K1_RPL = 32'h8000_0101
  } command_t;

  typedef struct packed {
    command_t    cmd;
    logic [31:0] len;
  } header_t;

  typedef enum logic [1:0] {
    DST_CTRL,
    DST_EQUI,
    DST_SECP,
    DST_IGN
  } cmd_dst_t;

  // Bit 0/1: equihash engine present, bit 2: secp256k1 engine present.
  localparam logic [63:0] FPGA_CMD_CAP = 64'h0000_0000_0000_0007;

  // Reply codes (cmd[31]=1) match no routed entry below, so they fall to DST_IGN.
  function automatic cmd_dst_t get_cmd_dst(header_t hdr);
    cmd_dst_t dst;
    dst = DST_IGN;
    case (hdr.cmd)
      RESET_FPGA, FPGA_STATUS: dst = DST_CTRL;
      VERIFY_EQUIHASH:         if (FPGA_CMD_CAP[1:0] != 2'b00) dst = DST_EQUI;
      VERIFY_SECP256K1_SIG:    if (FPGA_CMD_CAP[2]) dst = DST_SECP;
      default:                 dst = DST_IGN;
    endcase
    if (hdr.len < 32'd8) dst = DST_IGN;
    return dst;
  endfunction

  // 33-bit sum so len near 2^32 does not wrap to a tiny word count.
  function automatic logic [29:0] msg_words(logic [31:0] len);
    return 30'(({1'b0, len} + 33'd7) >> 3);
  endfunction

endpackage

// File: rtl/zcash_fpga_cmd_rx.sv
// Host RX command parser: routes each message to the control/equihash/secp256k1 engine or
// drains it and hands its header to the reply path. Idle-timeout recovery: ZCASH_CMD_RX_TIMEOUT_EN.
//   state | meaning
//   IDLE  | waiting for a header word
//   HDR   | registered header offered to the selected engine
//   FWD   | body words passed straight through to the engine
//   DROP  | discarding the remainder of an over-long or timed-out message
//   IGN   | header offered to the reply path while the body drains
module zcash_fpga_cmd_rx
  import zcash_fpga_pkg::*;
#(
  parameter int DAT_BITS = 64
`ifdef ZCASH_CMD_RX_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYC = 1024
`endif
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [DAT_BITS-1:0] i_rx_dat,
  input  logic                i_rx_val,
  input  logic                i_rx_sop,
  input  logic                i_rx_eop,
  output logic                o_rx_rdy,
  output logic [DAT_BITS-1:0] o_eng_dat,
  output logic [2:0]          o_eng_val,
  output logic                o_eng_sop,
  output logic                o_eng_eop,
  input  logic [2:0]          i_eng_rdy,
  output logic                o_ign_val,
  output logic [DAT_BITS-1:0] o_ign_hdr,
  input  logic                i_ign_rdy,
  input  logic                i_clr_err,
  output logic                o_err,
  output logic [31:0]         o_msg_cnt,
  output logic [31:0]         o_ign_cnt
);

  typedef enum logic [2:0] {S_IDLE, S_HDR, S_FWD, S_DROP, S_IGN} state_t;

  state_t      state, state_n;
  header_t     hdr_q, hdr_n, hdr_in;
  cmd_dst_t    sel_q, sel_n, dst_in;
  logic [29:0] words_q, words_n, cnt_q, cnt_n, cnt_inc;
  logic        hdr_eop_q, hdr_eop_n;
  logic        body_eop_q, body_eop_n;
  logic        ign_done_q, ign_done_n;
  logic        run_q;
  logic [2:0]  sel_mask;
  logic        sel_rdy;
  logic        body_now, ign_now;
  logic        err_set, msg_inc, ign_inc;

  assign hdr_in    = header_t'(i_rx_dat);
  assign dst_in    = get_cmd_dst(hdr_in);
  assign sel_mask  = 3'(3'b001 << sel_q);
  assign sel_rdy   = |(i_eng_rdy & sel_mask);
  assign cnt_inc   = cnt_q + 30'd1;
  assign o_ign_hdr = hdr_q;

`ifdef ZCASH_CMD_RX_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TMO_W-1:0] tmo_cnt;
  logic             tmo, tmo_act;

  assign tmo_act = (state == S_FWD) || (state == S_DROP) || (state == S_IGN);
  assign tmo     = (tmo_cnt == TMO_W'(TIMEOUT_CYC));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)                               tmo_cnt <= '0;
    else if (!tmo_act || (i_rx_val && o_rx_rdy)) tmo_cnt <= '0;
    else if (!i_rx_val && !tmo)              tmo_cnt <= tmo_cnt + TMO_W'(1);
  end
`endif

  always_comb begin
    state_n    = state;
    hdr_n      = hdr_q;
    sel_n      = sel_q;
    words_n    = words_q;
    cnt_n      = cnt_q;
    hdr_eop_n  = hdr_eop_q;
    body_eop_n = body_eop_q;
    ign_done_n = ign_done_q;
    o_rx_rdy   = 1'b0;
    o_eng_dat  = '0;
    o_eng_val  = 3'b000;
    o_eng_sop  = 1'b0;
    o_eng_eop  = 1'b0;
    o_ign_val  = 1'b0;
    body_now   = 1'b0;
    ign_now    = 1'b0;
    err_set    = 1'b0;
    msg_inc    = 1'b0;
    ign_inc    = 1'b0;
    case (state)
      S_IDLE: begin
        o_rx_rdy = run_q;
        if (i_rx_val && run_q) begin
          if (i_rx_sop) begin
            hdr_n      = hdr_in;
            sel_n      = dst_in;
            words_n    = msg_words(hdr_in.len);
            cnt_n      = 30'd1;
            hdr_eop_n  = i_rx_eop;
            body_eop_n = i_rx_eop;
            ign_done_n = 1'b0;
            err_set    = (hdr_in.len < 32'd8);
            state_n    = (dst_in == DST_IGN) ? S_IGN : S_HDR;
          end else begin
            err_set = 1'b1;
          end
        end
      end
      S_HDR: begin
        o_eng_dat = hdr_q;
        o_eng_val = sel_mask;
        o_eng_sop = 1'b1;
        o_eng_eop = hdr_eop_q || (words_q == 30'd1);
        if (sel_rdy) begin
          msg_inc = 1'b1;
          if (hdr_eop_q) begin
            err_set = (words_q != 30'd1);
            state_n = S_IDLE;
          end else if (words_q == 30'd1) begin
            err_set = 1'b1;
            state_n = S_DROP;
          end else begin
            state_n = S_FWD;
          end
        end
      end
      S_FWD: begin
`ifdef ZCASH_CMD_RX_TIMEOUT_EN
        if (tmo) begin
          o_eng_val = sel_mask;
          o_eng_eop = 1'b1;
          if (sel_rdy) begin
            err_set = 1'b1;
            state_n = S_IDLE;
          end
        end else
`endif
        begin
          o_eng_dat = i_rx_dat;
          o_eng_val = i_rx_val ? sel_mask : 3'b000;
          o_eng_eop = i_rx_eop || (cnt_inc == words_q);
          o_rx_rdy  = sel_rdy;
          if (i_rx_val && sel_rdy) begin
            cnt_n = cnt_inc;
            if (i_rx_eop) begin
              err_set = (cnt_inc != words_q);
              state_n = S_IDLE;
            end else if (cnt_inc == words_q) begin
              err_set = 1'b1;
              state_n = S_DROP;
            end
          end
        end
      end
      S_DROP: begin
        o_rx_rdy = 1'b1;
        if (i_rx_val && i_rx_eop) state_n = S_IDLE;
`ifdef ZCASH_CMD_RX_TIMEOUT_EN
        if (tmo) state_n = S_IDLE;
`endif
      end
      S_IGN: begin
        o_ign_val = !ign_done_q;
        o_rx_rdy  = !body_eop_q;
        body_now  = body_eop_q || (i_rx_val && i_rx_eop);
`ifdef ZCASH_CMD_RX_TIMEOUT_EN
        if (tmo) begin
          o_rx_rdy = 1'b0;
          body_now = 1'b1;
        end
`endif
        ign_now = ign_done_q || i_ign_rdy;
        if (o_rx_rdy && i_rx_val && i_rx_eop) body_eop_n = 1'b1;
        if (i_ign_rdy) ign_done_n = 1'b1;
        if (body_now && ign_now) begin
          ign_inc = 1'b1;
          state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state      <= S_IDLE;
      hdr_q      <= '0;
      sel_q      <= DST_IGN;
      words_q    <= '0;
      cnt_q      <= '0;
      hdr_eop_q  <= 1'b0;
      body_eop_q <= 1'b0;
      ign_done_q <= 1'b0;
      run_q      <= 1'b0;
      o_err      <= 1'b0;
      o_msg_cnt  <= '0;
      o_ign_cnt  <= '0;
    end else begin
      state      <= state_n;
      hdr_q      <= hdr_n;
      sel_q      <= sel_n;
      words_q    <= words_n;
      cnt_q      <= cnt_n;
      hdr_eop_q  <= hdr_eop_n;
      body_eop_q <= body_eop_n;
      ign_done_q <= ign_done_n;
      run_q      <= 1'b1;
      // a coinciding new error beats the clear
      if (err_set)        o_err <= 1'b1;
      else if (i_clr_err) o_err <= 1'b0;
      if (msg_inc) o_msg_cnt <= o_msg_cnt + 32'd1;
      if (ign_inc) o_ign_cnt <= o_ign_cnt + 32'd1;
    end
  end

endmodule
